// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// jumpSel encodings and the default reset PC.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [1:0] JSEL_SEQ = 2'b00;
   localparam logic [1:0] JSEL_BR  = 2'b01;
   localparam logic [1:0] JSEL_J   = 2'b10;
   localparam logic [1:0] JSEL_JR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DROP = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational control-transfer target generator; every target is relative
// to the PC of the instruction currently delivered to decode.
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [31:0] pc_out,
   input  logic [1:0]  jump_sel,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   output logic [31:0] target,
   output logic [31:0] pc_plus_four
);

   logic [31:0] branch_target;

   assign pc_plus_four  = pc_out + 32'd4;
   assign branch_target = pc_plus_four + {branch_offset[29:0], 2'b00};

   always_comb begin
      target = pc_plus_four;
      case (jump_sel)
         JSEL_SEQ: target = pc_plus_four;
         JSEL_BR:  target = branch_target;
         JSEL_J:   target = {pc_plus_four[31:28], jump_index, 2'b00};
         JSEL_JR:  target = jr_target;
         default:  target = pc_plus_four;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, imem request/response FSM and
// valid/ready hand-off to decode. Define FETCH_ALIGN_CHECK_EN to enable
// misaligned-redirect detection and PC alignment forcing.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imemReq,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic              imemGnt,
   input  logic              imemValid,
   input  logic [31:0]       imemData,
   output logic [31:0]       instrOut,
   output logic              instrValid,
   input  logic              instrReady,
   output logic [ADDR_W-1:0] pcOut,
   output logic [ADDR_W-1:0] pcPlusFour,
   input  logic              redirect,
   input  logic [1:0]        jumpSel,
   input  logic [31:0]       branchOffset,
   input  logic [25:0]       jumpIndex,
   input  logic [31:0]       jrTarget,
   output logic              misalignErr
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic [31:0]       target;
   logic [31:0]       load_pc;
   logic              take_redirect;

   next_pc_calc u_next_pc_calc (
      .pc_out        (pc_out_q),
      .jump_sel      (jumpSel),
      .branch_offset (branchOffset),
      .jump_index    (jumpIndex),
      .jr_target     (jrTarget),
      .target        (target),
      .pc_plus_four  (pcPlusFour)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign load_pc    = {target[31:2], 2'b00};
   assign misalign_d = misalign_q | (take_redirect & (target[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign misalignErr = misalign_q;
`else
   assign load_pc     = target;
   assign misalignErr = 1'b0;
`endif

   // A redirect always wins; it also marks any response still in flight as stale.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pc_out_d      = pc_out_q;
      instr_d       = instr_q;
      valid_d       = valid_q;
      take_redirect = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (redirect) begin
               take_redirect = 1'b1;
               pc_d          = load_pc;
               state_d       = imemGnt ? ST_DROP : ST_REQ;
            end else if (imemGnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               take_redirect = 1'b1;
               pc_d          = load_pc;
               state_d       = imemValid ? ST_REQ : ST_DROP;
            end else if (imemValid) begin
               instr_d  = imemData;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               take_redirect = 1'b1;
               pc_d          = load_pc;
            end
            if (imemValid) state_d = ST_REQ;
         end
         ST_HOLD: begin
            if (redirect) begin
               take_redirect = 1'b1;
               valid_d       = 1'b0;
               pc_d          = load_pc;
               state_d       = ST_REQ;
            end else if (instrReady) begin
               valid_d = 1'b0;
               pc_d    = pcPlusFour;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         pc_out_q <= RESET_PC;
         instr_q  <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
      end
   end

   assign imemReq    = (state_q == ST_REQ);
   assign imemAddr   = pc_q;
   assign instrOut   = instr_q;
   assign instrValid = valid_q;
   assign pcOut      = pc_out_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: hand-driven imem handshake,
// redirects from every state, wrap-around, stall and asynchronous reset.
module tb_pc_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemValid;
   logic [31:0] imemData;
   logic [31:0] instrOut;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] pcOut;
   logic [31:0] pcPlusFour;
   logic        redirect;
   logic [1:0]  jumpSel;
   logic [31:0] branchOffset;
   logic [25:0] jumpIndex;
   logic [31:0] jrTarget;
   logic        misalignErr;

   int compared   = 0;
   int mismatched = 0;

   pc_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imemReq      (imemReq),
      .imemAddr     (imemAddr),
      .imemGnt      (imemGnt),
      .imemValid    (imemValid),
      .imemData     (imemData),
      .instrOut     (instrOut),
      .instrValid   (instrValid),
      .instrReady   (instrReady),
      .pcOut        (pcOut),
      .pcPlusFour   (pcPlusFour),
      .redirect     (redirect),
      .jumpSel      (jumpSel),
      .branchOffset (branchOffset),
      .jumpIndex    (jumpIndex),
      .jrTarget     (jrTarget),
      .misalignErr  (misalignErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic gnt, input logic vld, input logic [31:0] data,
                                input logic rdy, input logic redir, input logic [1:0] jsel);
      imemGnt    = gnt;
      imemValid  = vld;
      imemData   = data;
      instrReady = rdy;
      redirect   = redir;
      jumpSel    = jsel;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      imemGnt      = 1'b0;
      imemValid    = 1'b0;
      imemData     = 32'h0;
      instrReady   = 1'b0;
      redirect     = 1'b0;
      jumpSel      = JSEL_SEQ;
      branchOffset = 32'h0;
      jumpIndex    = 26'h0;
      jrTarget     = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req",      {31'h0, imemReq},     32'h0);
      checkOutput("rst_addr",     imemAddr,             32'h0);
      checkOutput("rst_valid",    {31'h0, instrValid},  32'h0);
      checkOutput("rst_instr",    instrOut,             32'h0);
      checkOutput("rst_pcout",    pcOut,                32'h0);
      checkOutput("rst_pc4",      pcPlusFour,           32'h4);
      checkOutput("rst_misalign", {31'h0, misalignErr}, 32'h0);

      // First fetch: IDLE, REQ at 0, WAIT, HOLD, then consume
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t1_req",  {31'h0, imemReq}, 32'h1);
      checkOutput("t1_addr", imemAddr,         32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("t1_wait_req", {31'h0, imemReq}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h2008_0005, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("t1_valid", {31'h0, instrValid}, 32'h1);
      checkOutput("t1_instr", instrOut,            32'h2008_0005);
      checkOutput("t1_pcout", pcOut,               32'h0);
      checkOutput("t1_pc4",   pcPlusFour,          32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("t1_addr2",  imemAddr,            32'h4);
      checkOutput("t1_req2",   {31'h0, imemReq},    32'h1);
      checkOutput("t1_valid2", {31'h0, instrValid}, 32'h0);

      // Stall in HOLD for five cycles
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'h8C08_0000, 1'b0, 1'b0, JSEL_SEQ);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
         checkOutput("t4_instr", instrOut,            32'h8C08_0000);
         checkOutput("t4_pcout", pcOut,               32'h4);
         checkOutput("t4_valid", {31'h0, instrValid}, 32'h1);
         checkOutput("t4_req",   {31'h0, imemReq},    32'h0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("t4_addr", imemAddr, 32'h8);

      // jr redirect in REQ without grant, then deliver at 0x10 and branch back
      jrTarget = 32'h0000_0010;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_JR);
      checkOutput("t2_jr_addr", imemAddr,         32'h10);
      checkOutput("t2_jr_req",  {31'h0, imemReq}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'hAC09_0004, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t2_pcout", pcOut, 32'h10);
      branchOffset = 32'hFFFF_FFFC;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_BR);
      checkOutput("t2_br_addr",  imemAddr,            32'h4);
      checkOutput("t2_br_valid", {31'h0, instrValid}, 32'h0);
      checkOutput("t2_br_req",   {31'h0, imemReq},    32'h1);

      // Redirect with grant goes to DROP; the stale response is discarded
      jrTarget = 32'h4000_0000;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_JR);
      checkOutput("t3_drop_req",  {31'h0, imemReq}, 32'h0);
      checkOutput("t3_drop_addr", imemAddr,         32'h4000_0000);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t3_drop_valid", {31'h0, instrValid}, 32'h0);
      checkOutput("t3_drop_req2",  {31'h0, imemReq},    32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t3_pcout", pcOut,    32'h4000_0000);
      checkOutput("t3_instr", instrOut, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("t3_seq_addr", imemAddr, 32'h4000_0004);

      // j redirect while WAIT: in-flight response must be dropped
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      jumpIndex = 26'h000_0100;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_J);
      checkOutput("t3_j_addr", imemAddr,         32'h4000_0400);
      checkOutput("t3_j_req",  {31'h0, imemReq}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t3_j_req_idle", {31'h0, imemReq}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t3_j_valid", {31'h0, instrValid}, 32'h0);
      checkOutput("t3_j_addr2", imemAddr,            32'h4000_0400);
      checkOutput("t3_j_req2",  {31'h0, imemReq},    32'h1);

      // Misaligned jr target
      jrTarget = 32'h0000_0102;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_JR);
`ifdef FETCH_ALIGN_CHECK_EN
      checkOutput("t5_addr",     imemAddr,             32'h0000_0100);
      checkOutput("t5_misalign", {31'h0, misalignErr}, 32'h1);
`else
      checkOutput("t5_addr",     imemAddr,             32'h0000_0102);
      checkOutput("t5_misalign", {31'h0, misalignErr}, 32'h0);
`endif

      // Sequential redirect coinciding with imemValid in WAIT returns to REQ
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 1'b1, JSEL_SEQ);
      checkOutput("t5_seq_addr",  imemAddr,            32'h4000_0004);
      checkOutput("t5_seq_valid", {31'h0, instrValid}, 32'h0);
      checkOutput("t5_seq_req",   {31'h0, imemReq},    32'h1);
`ifdef FETCH_ALIGN_CHECK_EN
      checkOutput("t5_sticky", {31'h0, misalignErr}, 32'h1);
`else
      checkOutput("t5_sticky", {31'h0, misalignErr}, 32'h0);
`endif

      // PC wrap from 0xFFFF_FFFC
      jrTarget = 32'hFFFF_FFFC;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JSEL_JR);
      checkOutput("wrap_addr", imemAddr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("wrap_pcout", pcOut,      32'hFFFF_FFFC);
      checkOutput("wrap_pc4",   pcPlusFour, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, JSEL_SEQ);
      checkOutput("wrap_addr2", imemAddr, 32'h0);

      // Asynchronous reset during WAIT
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      imemGnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_req",      {31'h0, imemReq},     32'h0);
      checkOutput("t6_valid",    {31'h0, instrValid},  32'h0);
      checkOutput("t6_instr",    instrOut,             32'h0);
      checkOutput("t6_pcout",    pcOut,                32'h0);
      checkOutput("t6_addr",     imemAddr,             32'h0);
      checkOutput("t6_misalign", {31'h0, misalignErr}, 32'h0);
      imemValid = 1'b1;
      imemData  = 32'h1111_1111;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t6_late_valid", {31'h0, instrValid}, 32'h0);
      checkOutput("t6_late_instr", instrOut,            32'h0);
      checkOutput("t6_restart_req",  {31'h0, imemReq},  32'h1);
      checkOutput("t6_restart_addr", imemAddr,          32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, JSEL_SEQ);
      applyStimulus(1'b0, 1'b1, 32'h2400_0001, 1'b0, 1'b0, JSEL_SEQ);
      checkOutput("t6_instr2", instrOut,            32'h2400_0001);
      checkOutput("t6_pcout2", pcOut,               32'h0);
      checkOutput("t6_valid2", {31'h0, instrValid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
